serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor: the inverse of the team's combinational full_adder. It computes diff = a - b - borrow_in one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop. A start/busy/done handshake lets lab top-levels and benches drive it. Results are held stable until the next accepted start.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
a  input  WIDTH  minuend, captured on the accepted start edge
b  input  WIDTH  subtrahend, captured on the accepted start edge
borrow_in  input  1  initial borrow, captured on the accepted start edge
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when a result is written
diff  output  WIDTH  registered result (a - b - borrow_in) mod 2^WIDTH
borrow_out  output  1  final borrow: 1 iff a < b + borrow_in (unsigned)
overflow  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])

Behaviour:
- Interface decision: one clock, clk; reset is rst_n, synchronous and active-low.
- Reset: any edge with rst_n=0 forces state=IDLE. It clears busy, done, diff, borrow_out, overflow, the bit counter, the shift registers and the borrow FF. Reset overrides start.
- Reset mid-operation: the computation is abandoned and outputs go to 0. There is no partial result.
- States: IDLE, SHIFT, DONE.
  - IDLE: on start=1, load a, b and borrow_in into the working regs, set counter=0, go to SHIFT, busy=1.
  - SHIFT: each edge feeds operand LSBs and the borrow FF to the full_subtractor cell. d = x^y^bin; bout = (~x&y) | (~(x^y)&bin). d shifts into the result MSB; both operands shift right; the borrow FF takes bout; the counter increments. Start is ignored.
  - End of SHIFT: on the edge where counter reaches WIDTH-1, write diff, borrow_out and overflow. Then busy=0, done=1, go to DONE.
  - DONE: lasts one cycle with done=1. If start=1, load new operands and go to SHIFT, giving a back-to-back run with no IDLE cycle. Otherwise go to IDLE. done=0 either way.
- Latency: the start edge is E0. Bits are processed on E1..E_WIDTH. done is high during the cycle after E_WIDTH. busy is high from E0 until E_WIDTH.
- diff, borrow_out and overflow change only on the completion edge or reset. They hold through IDLE and the next SHIFT.
- Inputs a, b and borrow_in may change freely after the start edge without affecting the result.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared header serial_sub_defs.vh: state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2, and a counter-width function/macro (clog2 of WIDTH).
- One sub-module, full_subtractor (x, y, borrow_in -> diff, borrow_out), purely combinational. It mirrors full_adder and has its own exhaustive 8-row bench.
- The top level holds the FSM, counter, two shift registers, borrow FF and output registers.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, borrow_in=0, start 1 cycle -> done after 8 bit-cycles; diff=0x02, borrow_out=0, overflow=0; busy high exactly 8 cycles.
2. a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1, overflow=0. Then a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1.
3. a=0x80, b=0x01 -> diff=0x7F, borrow_out=0, overflow=1. Then a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, overflow=1.
4. Start a=0x10, b=0x01. Pulse start with a=0xAA, b=0x55 on cycle 3 of SHIFT, and change a/b after E0 -> ignored; diff=0x0F; exactly one done pulse.
5. Start a=0x20, b=0x01. Hold start=1 during DONE with a=0x09, b=0x04 -> first done shows diff=0x1F. The second run starts with no IDLE gap; the second done is 9 cycles after the first, with diff=0x05.
6. Start a run, assert rst_n=0 on cycle 4 of SHIFT -> next edge busy=0, done=0, diff=0x00, borrow_out=0, overflow=0. No done pulse follows; a new start after reset computes correctly.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and the
// bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must index bits 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - borrow_in, the dual of full_adder.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    always_comb begin
        diff       = x ^ y ^ borrow_in;
        borrow_out = (~x & y) | (~(x ^ y) & borrow_in);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock through a single
// full_subtractor cell; start/busy/done handshake with held results.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic cell_diff;
    logic cell_bout;

    full_subtractor u_cell (
        .x          (a_q[0]),
        .y          (b_q[0]),
        .borrow_in  (brw_q),
        .diff       (cell_diff),
        .borrow_out (cell_bout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    brw_d   = borrow_in;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                brw_d = cell_bout;
                res_d = {cell_diff, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // On the last bit the operand LSBs are the original sign bits.
                    diff_d  = {cell_diff, res_q[WIDTH-1:1]};
                    bout_d  = cell_bout;
                    ovf_d   = (a_q[0] ^ b_q[0]) & (cell_diff ^ a_q[0]);
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: expected results queued at start,
// compared when done pulses.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        string            name;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mbin, input string nm);
        exp_t e;
        int   full;
        full   = int'(ma) - int'(mb) - int'(mbin);
        e.diff = WIDTH'(full);
        e.bout = (full < 0);
        e.ovf  = (ma[WIDTH-1] != mb[WIDTH-1]) && (e.diff[WIDTH-1] != ma[WIDTH-1]);
        e.name = nm;
        return e;
    endfunction

    // Monitor: one line per completed transaction.
    always @(posedge clk) begin
        #1;
        if (done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk({e.name, "_diff"}, 32'(diff), 32'(e.diff));
                chk({e.name, "_bout"}, 32'(borrow_out), 32'(e.bout));
                chk({e.name, "_ovf"}, 32'(overflow), 32'(e.ovf));
                $display("txn %s: diff=%02h bout=%0b ovf=%0b (exp %02h %0b %0b)",
                         e.name, diff, borrow_out, overflow, e.diff, e.bout, e.ovf);
            end
        end
    end

    // Drive a start for one cycle at the negedge, queueing the model result.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ibin, input string nm);
        a         = ia;
        b         = ib;
        borrow_in = ibin;
        start     = 1'b1;
        sb_q.push_back(model(ia, ib, ibin, nm));
        @(negedge clk);
        start     = 1'b0;
        a         = WIDTH'($urandom);
        b         = WIDTH'($urandom);
        borrow_in = 1'($urandom);
    endtask

    // Wait (bounded) for done, counting negedges where busy was high.
    task automatic wait_done(input string nm, output int busy_cnt);
        bit seen;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic run(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic ibin, input string nm);
        int bc;
        issue(ia, ib, ibin, nm);
        wait_done(nm, bc);
        @(negedge clk);
    endtask

    initial begin
        int bc;
        int d0;
        int gap;
        bit seen;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(borrow_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: basic, with busy length
        issue(8'h05, 8'h03, 1'b0, "t1");
        wait_done("t1", bc);
        chk("t1_busy_cycles", 32'(bc), 32'(WIDTH));
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(done), 32'd0);
        chk("t1_hold_diff", 32'(diff), 32'h02);

        // 2, 3: borrow and signed overflow corners
        run(8'h03, 8'h05, 1'b0, "t2a");
        run(8'h00, 8'h00, 1'b1, "t2b");
        run(8'h80, 8'h01, 1'b0, "t3a");
        run(8'h7F, 8'hFF, 1'b0, "t3b");
        run(8'hFF, 8'hFF, 1'b1, "edge_ff");
        run(8'h00, 8'hFF, 1'b1, "edge_00");

        // 4: start during SHIFT is ignored
        d0 = n_done;
        issue(8'h10, 8'h01, 1'b0, "t4");
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4", bc);
        repeat (12) @(negedge clk);
        chk("t4_one_done", 32'(n_done - d0), 32'd1);

        // 5: back-to-back run from DONE
        issue(8'h20, 8'h01, 1'b0, "t5a");
        wait_done("t5a", bc);
        issue(8'h09, 8'h04, 1'b0, "t5b");
        gap  = 1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            gap++;
            @(negedge clk);
        end
        chk("t5_second_done_seen", 32'(seen), 32'd1);
        chk("t5_done_gap", 32'(gap), 32'd9);
        @(negedge clk);

        // 6: reset mid-operation
        d0 = n_done;
        issue(8'h44, 8'h11, 1'b0, "t6_abandoned");
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_diff", 32'(diff), 32'd0);
        chk("t6_bout", 32'(borrow_out), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("t6_no_done", 32'(n_done - d0), 32'd0);
        run(8'h44, 8'h11, 1'b0, "t6_after");

        // Random sweep
        for (int i = 0; i < 8; i++) begin
            run(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
